// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the non-stallable pipeline result with a FIFO of
// long-latency results onto the single register-file write port, and reports
// which registers still have queued writes.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_valid,
  input  logic [4:0]              pipe_addr,
  input  logic [31:0]             pipe_data,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [4:0]              lu_addr,
  input  logic [31:0]             lu_data,
  output logic                    write,
  output logic [4:0]              wrAddr,
  output logic [31:0]             wrData,
  output logic                    stall,
  output logic [31:0]             pend_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CountFull  = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne   = CW'(1);
  localparam logic [SW-1:0] StarveLast = SW'(STARVE_MAX - 1);

  // FIFO storage and bookkeeping
  logic [4:0]       addrMem [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [DEPTH-1:0] validQ, validD;
  logic [AW-1:0]    rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CW-1:0]    countQ, countD;

  // Arbitration state and output stage
  logic [SW-1:0]    starveQ, starveD;
  logic             stallQ, stallD;
  logic             writeQ, writeD;
  logic [4:0]       wrAddrQ, wrAddrD;
  logic [31:0]      wrDataQ, wrDataD;

  logic pipeWr, fifoWr, enq, deq, loss;

  assign pipeWr   = pipe_valid && (pipe_addr != 5'd0);
  assign fifoWr   = (countQ != '0);
  assign lu_ready = (countQ != CountFull);
  // x0 results are accepted (ready is honoured) but never stored
  assign enq      = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign deq      = fifoWr && !pipeWr;
  assign loss     = fifoWr && pipeWr;

  assign write      = writeQ;
  assign wrAddr     = wrAddrQ;
  assign wrData     = wrDataQ;
  assign stall      = stallQ;
  assign fifo_count = countQ;

  // Pending-destination mask: one-hot OR over occupied entries
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (validQ[i]) pend_mask[addrMem[i]] = 1'b1;
    end
  end

  // FIFO pointer, occupancy and valid-bit next state
  always_comb begin
    validD = validQ;
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;
    countD = countQ;
    if (deq) begin
      validD[rdPtrQ] = 1'b0;
      rdPtrD         = rdPtrQ + AW'(1);
    end
    if (enq) begin
      validD[wrPtrQ] = 1'b1;
      wrPtrD         = wrPtrQ + AW'(1);
    end
    unique case ({enq, deq})
      2'b10:   countD = countQ + CountOne;
      2'b01:   countD = countQ - CountOne;
      default: countD = countQ;
    endcase
  end

  // Winner selection, starvation tracking and stall request
  always_comb begin
    writeD  = 1'b0;
    wrAddrD = wrAddrQ;
    wrDataD = wrDataQ;
    starveD = '0;
    stallD  = stallQ;
    if (pipeWr) begin
      writeD  = 1'b1;
      wrAddrD = pipe_addr;
      wrDataD = pipe_data;
    end else if (fifoWr) begin
      writeD  = 1'b1;
      wrAddrD = addrMem[rdPtrQ];
      wrDataD = dataMem[rdPtrQ];
    end
    if (loss) begin
      // Counter saturates so repeated losses keep re-asserting stall
      starveD = (starveQ == StarveLast) ? starveQ : starveQ + SW'(1);
      if (starveQ == StarveLast) stallD = 1'b1;
    end else if (!fifoWr) begin
      stallD = 1'b0;
    end else if (countD <= CountOne) begin
      // FIFO won and at most one entry remains: it drains without help
      stallD = 1'b0;
    end
  end

  // FIFO payload storage (no reset needed; guarded by valid bits)
  always_ff @(posedge clk) begin
    if (enq) begin
      addrMem[wrPtrQ] <= lu_addr;
      dataMem[wrPtrQ] <= lu_data;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validQ  <= '0;
      rdPtrQ  <= '0;
      wrPtrQ  <= '0;
      countQ  <= '0;
      starveQ <= '0;
      stallQ  <= 1'b0;
      writeQ  <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
    end else begin
      validQ  <= validD;
      rdPtrQ  <= rdPtrD;
      wrPtrQ  <= wrPtrD;
      countQ  <= countD;
      starveQ <= starveD;
      stallQ  <= stallD;
      writeQ  <= writeD;
      wrAddrQ <= wrAddrD;
      wrDataQ <= wrDataD;
    end
  end

endmodule
